// File: rtl/lc3_mem_responder.sv
// ---------------------------------------------------------------------------
// lc3_mem_responder
//   Memory-side responder for the LC3 memory bus. It holds a word RAM behind a
//   four-phase request/complete handshake with a fixed number of wait states.
//   It also decodes the display registers DSR (xFE04) and DDR (xFE06), which
//   feed a one-entry character output stream.
//
//   Bus handshake: the CPU raises mem_en with rw/addr/wdata stable. The
//   responder latches them in IDLE and raises complete once the access is done.
//   It holds complete until mem_en drops.
//   Display handshake: a character moves on any rising edge with
//   dd_valid=1 and dd_ready=1.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   mem_en       CPU request strobe, held until complete is seen
//   rw           1 = read, 0 = write (sampled with mem_en)
//   addr         16-bit word address (sampled with mem_en)
//   wdata        CPU write data (sampled with mem_en)
//   rdata        read data, updated on each completed read
//   complete     access finished, held until mem_en drops
//   dd_valid     display character pending
//   dd_data      display character
//   dd_ready     display sink ready
//   dbg_state_o  FSM state (0 IDLE, 1 ACCESS, 2 DONE)
// ---------------------------------------------------------------------------
module lc3_mem_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_en,
   input  logic        rw,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        complete,
   output logic        dd_valid,
   output logic [7:0]  dd_data,
   input  logic        dd_ready,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
   localparam logic [15:0] DSR_ADDR  = 16'hFE04;
   localparam logic [15:0] DDR_ADDR  = 16'hFE06;
   localparam logic [15:0] IO_BASE   = 16'hFE00;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        rw_q;
   logic [15:0] addr_q;
   logic [15:0] wdata_q;
   logic [15:0] rdata_q, rdata_d;
   logic        dd_valid_q, dd_valid_d;
   logic [7:0]  dd_data_q, dd_data_d;

   logic [15:0] ram [0:(1<<ADDR_W)-1];

   logic        latch_req;
   logic        access_fire;
   logic        is_ram, is_dsr, is_ddr;
   logic [15:0] read_val;
   logic        ddr_load;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (mem_en) state_d = S_ACCESS;
         S_ACCESS: if (cnt_q == 4'd0) state_d = S_DONE;
         S_DONE:   if (!mem_en) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      complete    = (state_q == S_DONE);
      dbg_state_o = state_q;
   end

   assign latch_req   = (state_q == S_IDLE) && mem_en;
   assign access_fire = (state_q == S_ACCESS) && (cnt_q == 4'd0);

   // Decode works on the latched address, so bus changes after the request
   // edge have no effect.
   assign is_ram = (addr_q < IO_BASE);
   assign is_dsr = (addr_q == DSR_ADDR);
   assign is_ddr = (addr_q == DDR_ADDR);

   always_comb begin
      read_val = 16'h0000;
      if (is_ram)      read_val = ram[addr_q[ADDR_W-1:0]];
      else if (is_dsr) read_val = {~dd_valid_q, 15'b0};
      else if (is_ddr) read_val = {8'h00, dd_data_q};
   end

   // A DDR write is accepted when the slot is empty, or when it is emptying
   // on this same edge.
   assign ddr_load = access_fire && !rw_q && is_ddr && (!dd_valid_q || dd_ready);

   always_comb begin
      cnt_d = cnt_q;
      if (latch_req)                               cnt_d = WAIT_INIT;
      else if (state_q == S_ACCESS && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;

      rdata_d = rdata_q;
      if (access_fire && rw_q) rdata_d = read_val;

      // A new character takes priority over clearing the pending one.
      dd_valid_d = dd_valid_q;
      dd_data_d  = dd_data_q;
      if (ddr_load) begin
         dd_valid_d = 1'b1;
         dd_data_d  = wdata_q[7:0];
      end else if (dd_valid_q && dd_ready) begin
         dd_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q      <= 4'd0;
         rw_q       <= 1'b1;
         addr_q     <= 16'h0000;
         wdata_q    <= 16'h0000;
         rdata_q    <= 16'h0000;
         dd_valid_q <= 1'b0;
         dd_data_q  <= 8'h00;
      end else begin
         cnt_q      <= cnt_d;
         rdata_q    <= rdata_d;
         dd_valid_q <= dd_valid_d;
         dd_data_q  <= dd_data_d;
         if (latch_req) begin
            rw_q    <= rw;
            addr_q  <= addr;
            wdata_q <= wdata;
         end
      end
   end

   // RAM is not reset. A reset forces the FSM to IDLE, so no access fires
   // while reset is asserted and an interrupted write is dropped.
   always_ff @(posedge clk) begin
      if (access_fire && !rw_q && is_ram) begin
         ram[addr_q[ADDR_W-1:0]] <= wdata_q;
      end
   end

   assign rdata    = rdata_q;
   assign dd_valid = dd_valid_q;
   assign dd_data  = dd_data_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
module tb_lc3_mem_responder;

   localparam int ADDR_W      = 10;
   localparam int WAIT_CYCLES = 2;
   localparam int DEPTH       = 1 << ADDR_W;

   logic        clk;
   logic        reset;
   logic        mem_en;
   logic        rw;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        complete;
   logic        dd_valid;
   logic [7:0]  dd_data;
   logic        dd_ready;
   logic [1:0]  dbg_state;

   lc3_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_en     (mem_en),
      .rw         (rw),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .complete   (complete),
      .dd_valid   (dd_valid),
      .dd_data    (dd_data),
      .dd_ready   (dd_ready),
      .dbg_state_o(dbg_state)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   logic [15:0] mem_m [0:DEPTH-1];
   logic [15:0] exp_rdata;
   logic        exp_valid;
   logic [7:0]  exp_data;
   logic [15:0] exp_q [$];

   int n_cmp;
   int n_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One bus access as the CPU sees it, applied at the access edge.
   // rdy is the sink readiness at that edge.
   task automatic model_access(input logic r, input logic [15:0] a,
                               input logic [15:0] d, input logic rdy);
      int idx;
      logic [15:0] v;
      idx = int'(a) % DEPTH;
      if (r) begin
         if (a < 16'hFE00)       v = mem_m[idx];
         else if (a == 16'hFE04) v = exp_valid ? 16'h0000 : 16'h8000;
         else if (a == 16'hFE06) v = {8'h00, exp_data};
         else                    v = 16'h0000;
         exp_rdata = v;
         exp_q.push_back(v);
         if (rdy) exp_valid = 1'b0;
      end else begin
         if (a < 16'hFE00) mem_m[idx] = d;
         if (a == 16'hFE06 && (!exp_valid || rdy)) begin
            exp_valid = 1'b1;
            exp_data  = d[7:0];
         end else if (rdy) begin
            exp_valid = 1'b0;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic bus_op(input logic r, input logic [15:0] a, input logic [15:0] d,
                         input logic rdy, input int hold);
      int k;
      logic got;
      logic [15:0] e;
      model_access(r, a, d, rdy);
      @(negedge clk);
      mem_en = 1'b1; rw = r; addr = a; wdata = d;
      k = 0;
      got = 1'b0;
      while (!got && k < 40) begin
         if (k == WAIT_CYCLES + 1) dd_ready = rdy;
         @(negedge clk);
         k++;
         if (k == 1) begin
            // latched values must win over these
            addr  = 16'($urandom);
            wdata = 16'($urandom);
            rw    = 1'($urandom);
         end
         got = complete;
      end
      dd_ready = 1'b0;
      check("latency", 32'(k - 1), 32'(WAIT_CYCLES + 1));
      if (!got) begin
         mem_en = 1'b0;
         if (r) void'(exp_q.pop_front());
         return;
      end
      if (r) begin
         e = exp_q.pop_front();
         check("rdata", {16'h0, rdata}, {16'h0, e});
      end else begin
         check("rdata_hold", {16'h0, rdata}, {16'h0, exp_rdata});
      end
      check("dd_valid", {31'h0, dd_valid}, {31'h0, exp_valid});
      check("dd_data", {24'h0, dd_data}, {24'h0, exp_data});
      for (int i = 0; i < hold; i++) begin
         addr  = 16'($urandom);
         wdata = 16'($urandom);
         rw    = 1'($urandom);
         @(negedge clk);
         check("held_complete", {31'h0, complete}, 32'h1);
      end
      mem_en = 1'b0;
      addr   = 16'($urandom);
      @(negedge clk);
      check("complete_drop", {31'h0, complete}, 32'h0);
   endtask

   task automatic drain();
      @(negedge clk);
      dd_ready = 1'b1;
      @(negedge clk);
      dd_ready = 1'b0;
      exp_valid = 1'b0;
      check("drain_valid", {31'h0, dd_valid}, 32'h0);
      check("drain_data", {24'h0, dd_data}, {24'h0, exp_data});
   endtask

   task automatic reset_mid_write(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      mem_en = 1'b1; rw = 1'b0; addr = a; wdata = d;
      @(negedge clk);
      check("mid_in_access", {30'h0, dbg_state}, 32'h1);
      #2 reset = 1'b0;
      #1;
      check("mid_complete", {31'h0, complete}, 32'h0);
      check("mid_state", {30'h0, dbg_state}, 32'h0);
      check("mid_rdata", {16'h0, rdata}, 32'h0);
      check("mid_dd_valid", {31'h0, dd_valid}, 32'h0);
      mem_en = 1'b0;
      exp_rdata = 16'h0000;
      exp_valid = 1'b0;
      exp_data  = 8'h00;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] a;
      logic [15:0] d;
      int sel;
      n_cmp = 0;
      n_err = 0;
      exp_rdata = 16'h0000;
      exp_valid = 1'b0;
      exp_data  = 8'h00;
      reset = 1'b0; mem_en = 1'b0; rw = 1'b1; addr = 16'h0; wdata = 16'h0; dd_ready = 1'b0;

      #3;
      check("rst_complete", {31'h0, complete}, 32'h0);
      check("rst_rdata", {16'h0, rdata}, 32'h0);
      check("rst_dd_valid", {31'h0, dd_valid}, 32'h0);
      check("rst_dd_data", {24'h0, dd_data}, 32'h0);
      check("rst_state", {30'h0, dbg_state}, 32'h0);
      #7 reset = 1'b1;

      // basic write/read
      bus_op(1'b0, 16'h0005, 16'h1234, 1'b0, 0);
      bus_op(1'b1, 16'h0005, 16'h0000, 1'b0, 0);
      check("read_1234", {16'h0, rdata}, 32'h1234);

      // held request: exactly one access, perturbed bus ignored
      bus_op(1'b0, 16'h0020, 16'hCAFE, 1'b0, 10);
      bus_op(1'b1, 16'h0020, 16'h0000, 1'b0, 10);
      check("held_once", {16'h0, rdata}, 32'hCAFE);

      // aliasing and unmapped I/O
      bus_op(1'b0, 16'h0403, 16'hBEEF, 1'b0, 0);
      bus_op(1'b1, 16'h0003, 16'h0000, 1'b0, 0);
      check("alias", {16'h0, rdata}, 32'hBEEF);
      bus_op(1'b1, 16'hFE10, 16'h0000, 1'b0, 0);
      check("unmapped", {16'h0, rdata}, 32'h0000);

      // display path
      bus_op(1'b1, 16'hFE04, 16'h0000, 1'b0, 0);
      check("dsr_empty", {16'h0, rdata}, 32'h8000);
      bus_op(1'b0, 16'hFE06, 16'h0041, 1'b0, 0);
      check("ddr_load", {23'h0, dd_valid, dd_data}, 32'h141);
      bus_op(1'b1, 16'hFE04, 16'h0000, 1'b0, 0);
      check("dsr_full", {16'h0, rdata}, 32'h0000);
      bus_op(1'b0, 16'hFE06, 16'h0042, 1'b0, 0);
      check("ddr_dropped", {24'h0, dd_data}, 32'h41);
      bus_op(1'b1, 16'hFE06, 16'h0000, 1'b0, 0);
      check("ddr_read", {16'h0, rdata}, 32'h0041);
      drain();
      bus_op(1'b1, 16'hFE04, 16'h0000, 1'b0, 0);
      check("dsr_drained", {16'h0, rdata}, 32'h8000);

      // transfer and load on the same edge
      bus_op(1'b0, 16'hFE06, 16'h0050, 1'b0, 0);
      bus_op(1'b0, 16'hFE06, 16'h0043, 1'b1, 0);
      check("simul", {23'h0, dd_valid, dd_data}, 32'h143);
      drain();

      // reset during a write access
      bus_op(1'b0, 16'h0010, 16'h5555, 1'b0, 0);
      reset_mid_write(16'h0010, 16'hAAAA);
      bus_op(1'b1, 16'h0010, 16'h0000, 1'b0, 0);
      check("abort_write", {16'h0, rdata}, 32'h5555);

      // randomized traffic over a preloaded window
      for (int i = 0; i < 64; i++) bus_op(1'b0, 16'(i), 16'($urandom), 1'b0, 0);
      for (int i = 0; i < 250; i++) begin
         sel = $urandom_range(0, 9);
         d   = 16'($urandom);
         if (sel < 6) begin
            a = 16'(($urandom_range(0, 63) << ADDR_W) | $urandom_range(0, 63));
         end else if (sel == 6) begin
            a = 16'hFE04;
         end else if (sel == 7) begin
            a = 16'hFE06;
         end else begin
            a = 16'(16'hFE00 + $urandom_range(0, 16'h1FF));
            if (a == 16'hFE04 || a == 16'hFE06) a = 16'hFE08;
         end
         bus_op(1'($urandom), a, d, ($urandom_range(0, 2) == 0), $urandom_range(0, 2));
         if ($urandom_range(0, 7) == 0) drain();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
